// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared pipeline constants for the memory stage
package memory_stage_pkg;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  // Unlisted codes fall back to word-sized accesses.
  function automatic access_size_e access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - execute-side inputs and writeback-side outputs of the memory stage
interface memory_stage_if;

  logic [4:0]  RD_E;
  logic        RegWriteEn_E;
  logic        MemtoReg_E;
  logic        MemWrite_E;
  logic        JAL_E;
  logic [2:0]  Funct3_E;
  logic [31:0] ALU_Result_E;
  logic [31:0] WriteData_E;
  logic [31:0] PCPlus4_E;
  logic        Stall_M;
  logic        Flush_M;

  logic [4:0]  RD_M;
  logic        RegWriteEn_M;
  logic        MemtoReg_M;
  logic        JAL_M;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic        Misaligned_M;

  modport master (
    output RD_E, RegWriteEn_E, MemtoReg_E, MemWrite_E, JAL_E, Funct3_E,
           ALU_Result_E, WriteData_E, PCPlus4_E, Stall_M, Flush_M,
    input  RD_M, RegWriteEn_M, MemtoReg_M, JAL_M, PCPlus4W, ALU_ResultW,
           ReadDataW, Misaligned_M
  );

  modport slave (
    input  RD_E, RegWriteEn_E, MemtoReg_E, MemWrite_E, JAL_E, Funct3_E,
           ALU_Result_E, WriteData_E, PCPlus4_E, Stall_M, Flush_M,
    output RD_M, RegWriteEn_M, MemtoReg_M, JAL_M, PCPlus4W, ALU_ResultW,
           ReadDataW, Misaligned_M
  );

endinterface

// File: rtl/memory_stage_data_memory.sv
// rtl/memory_stage_data_memory.sv - word-organised data RAM with byte-strobe write and async read
module data_memory
  import memory_stage_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         strb,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - EX/MEM pipeline register, data memory access and load extension
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  memory_stage_if.slave bus
);

  logic [4:0]   rd_m;
  logic         regwrite_m, memtoreg_m, memwrite_m, jal_m;
  logic [2:0]   funct3_m;
  logic [31:0]  alu_result_m, write_data_m, pcplus4_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_m         <= '0;
      regwrite_m   <= 1'b0;
      memtoreg_m   <= 1'b0;
      memwrite_m   <= 1'b0;
      jal_m        <= 1'b0;
      funct3_m     <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pcplus4_m    <= '0;
    end else if (!bus.Stall_M) begin
      regwrite_m   <= bus.Flush_M ? 1'b0 : bus.RegWriteEn_E;
      memtoreg_m   <= bus.Flush_M ? 1'b0 : bus.MemtoReg_E;
      memwrite_m   <= bus.Flush_M ? 1'b0 : bus.MemWrite_E;
      jal_m        <= bus.Flush_M ? 1'b0 : bus.JAL_E;
      rd_m         <= bus.RD_E;
      funct3_m     <= bus.Funct3_E;
      alu_result_m <= bus.ALU_Result_E;
      write_data_m <= bus.WriteData_E;
      pcplus4_m    <= bus.PCPlus4_E;
    end
  end

  access_size_e size_m;
  logic [1:0]   offset_m;
  logic         misaligned;
  logic         mem_we;
  logic [3:0]   mem_strb;
  logic [31:0]  mem_wdata, mem_rdata, lane_word, load_data;

  assign size_m   = access_size(funct3_m);
  assign offset_m = alu_result_m[1:0];

  always_comb begin
    misaligned = 1'b0;
    if (memtoreg_m || memwrite_m) begin
      case (size_m)
        SZ_HALF: misaligned = offset_m[0];
        SZ_WORD: misaligned = (offset_m != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Gating on rst keeps a store caught by reset from landing in memory.
  assign mem_we = memwrite_m && !bus.Stall_M && !misaligned && !rst;

  always_comb begin
    mem_strb  = 4'b1111;
    mem_wdata = write_data_m;
    case (size_m)
      SZ_BYTE: begin
        mem_strb  = 4'b0001 << offset_m;
        mem_wdata = {4{write_data_m[7:0]}};
      end
      SZ_HALF: begin
        mem_strb  = offset_m[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{write_data_m[15:0]}};
      end
      default: begin
        mem_strb  = 4'b1111;
        mem_wdata = write_data_m;
      end
    endcase
  end

  data_memory u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .strb  (mem_strb),
    .addr  (alu_result_m[DMEM_AW+1:2]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Shift the addressed lane down to bit 0 before extension.
  assign lane_word = mem_rdata >> {offset_m, 3'b000};

  always_comb begin
    load_data = mem_rdata;
    case (funct3_m)
      F3_LB:   load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      F3_LH:   load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      F3_LBU:  load_data = {24'd0, lane_word[7:0]};
      F3_LHU:  load_data = {16'd0, lane_word[15:0]};
      default: load_data = mem_rdata;
    endcase
    if (misaligned) load_data = '0;
  end

  assign bus.RD_M         = rd_m;
  assign bus.RegWriteEn_M = regwrite_m;
  assign bus.MemtoReg_M   = memtoreg_m;
  assign bus.JAL_M        = jal_m;
  assign bus.PCPlus4W     = pcplus4_m;
  assign bus.ALU_ResultW  = alu_result_m;
  assign bus.ReadDataW    = load_data;
  assign bus.Misaligned_M = misaligned;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  memory_stage_if bus ();

  memory_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic mw, input logic jal, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc, input logic stall, input logic flush);
    bus.RD_E         = rd;
    bus.RegWriteEn_E = rw;
    bus.MemtoReg_E   = m2r;
    bus.MemWrite_E   = mw;
    bus.JAL_E        = jal;
    bus.Funct3_E     = f3;
    bus.ALU_Result_E = alu;
    bus.WriteData_E  = wd;
    bus.PCPlus4_E    = pc;
    bus.Stall_M      = stall;
    bus.Flush_M      = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic stall, input logic flush);
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, stall, flush);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    drive(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, f3, a, d, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    drive(rd, 1'b1, 1'b1, 1'b0, 1'b0, f3, a, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rd"},   32'(bus.RD_M), 32'd0);
    check({tag, "_ctrl"}, {29'd0, bus.RegWriteEn_M, bus.MemtoReg_M, bus.JAL_M}, 32'd0);
    check({tag, "_alu"},  bus.ALU_ResultW, 32'd0);
    check({tag, "_pc"},   bus.PCPlus4W, 32'd0);
    check({tag, "_mis"},  32'(bus.Misaligned_M), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    nop(1'b0, 1'b0);
    check_cleared("reset");
    rst = 1'b0;

    store(3'b010, 32'h0000_0000, 32'h0000_00F5);
    store(3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    load(3'b010, 32'h0000_0010, 5'd5);
    check("raw_lw", bus.ReadDataW, 32'hDEAD_BEEF);
    check("raw_m2r", 32'(bus.MemtoReg_M), 32'd1);
    check("raw_rd", 32'(bus.RD_M), 32'd5);
    check("raw_rw", 32'(bus.RegWriteEn_M), 32'd1);

    store(3'b010, 32'h0000_0010, 32'h80F0_0180);
    load(3'b000, 32'h0000_0013, 5'd6);
    check("lb", bus.ReadDataW, 32'hFFFF_FF80);
    load(3'b100, 32'h0000_0013, 5'd6);
    check("lbu", bus.ReadDataW, 32'h0000_0080);
    load(3'b001, 32'h0000_0012, 5'd6);
    check("lh", bus.ReadDataW, 32'hFFFF_80F0);
    load(3'b101, 32'h0000_0012, 5'd6);
    check("lhu", bus.ReadDataW, 32'h0000_80F0);
    load(3'b000, 32'h0000_0010, 5'd6);
    check("lb_lane0", bus.ReadDataW, 32'hFFFF_FF80);
    store(3'b000, 32'h0000_0011, 32'hFFFF_FFAB);
    load(3'b010, 32'h0000_0010, 5'd6);
    check("sb_word", bus.ReadDataW, 32'h80F0_AB80);
    store(3'b001, 32'h0000_0012, 32'h1234_5566);
    load(3'b010, 32'h0000_0010, 5'd6);
    check("sh_word", bus.ReadDataW, 32'h5566_AB80);

    store(3'b010, 32'h0000_0410, 32'hCAFE_F00D);
    load(3'b010, 32'h0000_0010, 5'd6);
    check("addr_wrap", bus.ReadDataW, 32'hCAFE_F00D);

    store(3'b010, 32'h0000_0020, 32'h1111_1111);
    store(3'b010, 32'h0000_0020, 32'h2222_2222);
    for (int i = 0; i < 3; i++) begin
      nop(1'b1, 1'b0);
      check($sformatf("stall%0d_old", i), bus.ReadDataW, 32'h1111_1111);
      check($sformatf("stall%0d_alu", i), bus.ALU_ResultW, 32'h0000_0020);
    end
    load(3'b010, 32'h0000_0020, 5'd7);
    check("stall_written", bus.ReadDataW, 32'h2222_2222);

    store(3'b010, 32'h0000_0030, 32'h3333_3333);
    drive(5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h4444_4444, 32'h0, 1'b0, 1'b1);
    check("flush_rw", 32'(bus.RegWriteEn_M), 32'd0);
    check("flush_mw_m2r", 32'(bus.MemtoReg_M), 32'd0);
    load(3'b010, 32'h0000_0030, 5'd7);
    check("flush_nowrite", bus.ReadDataW, 32'h3333_3333);
    drive(5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h44, 32'h0, 32'h8, 1'b1, 1'b1);
    check("stflush_rd", 32'(bus.RD_M), 32'd7);
    check("stflush_ctrl", {29'd0, bus.RegWriteEn_M, bus.MemtoReg_M, bus.JAL_M}, 32'd6);
    check("stflush_data", bus.ReadDataW, 32'h3333_3333);

    load(3'b010, 32'h0000_0022, 5'd8);
    check("mis_lw_flag", 32'(bus.Misaligned_M), 32'd1);
    check("mis_lw_data", bus.ReadDataW, 32'd0);
    check("mis_lw_m2r", 32'(bus.MemtoReg_M), 32'd1);
    store(3'b001, 32'h0000_0023, 32'h0000_5555);
    check("mis_sh_flag", 32'(bus.Misaligned_M), 32'd1);
    load(3'b010, 32'h0000_0020, 5'd8);
    check("mis_sh_nowrite", bus.ReadDataW, 32'h2222_2222);
    check("aligned_flag", 32'(bus.Misaligned_M), 32'd0);
    drive(5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h23, 32'h0, 32'h0, 1'b0, 1'b0);
    check("alu_op_flag", 32'(bus.Misaligned_M), 32'd0);

    store(3'b010, 32'h0000_0040, 32'h1234_5678);
    store(3'b010, 32'h0000_0040, 32'h9999_9999);
    rst = 1'b1;
    nop(1'b1, 1'b1);
    check_cleared("rst_mid");
    check("rst_rdata", bus.ReadDataW, 32'hFFFF_FFF5);
    rst = 1'b0;
    load(3'b010, 32'h0000_0040, 5'd2);
    check("rst_nowrite", bus.ReadDataW, 32'h1234_5678);

    drive(5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_F000, 1'b0, 1'b0);
    check("jal_flag", 32'(bus.JAL_M), 32'd1);
    check("jal_pc", bus.PCPlus4W, 32'h0000_F000);
    check("jal_rd", 32'(bus.RD_M), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
